// File: rtl/instrmem_loader.sv
// Boot-time instruction memory loader: 4-byte LE length, then LE 32-bit words written at byte addresses 0,4,8,...
// Optional trailer checksum byte enabled by defining INSTRMEM_LOADER_CHECKSUM_EN.
module instrmem_loader #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDRESS_WIDTH:0]  word_count
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready;
  // rx_ready is registered and depends only on state, never on rx_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_FLUSH, S_CSUM, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [23:0]             buf_q, buf_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [ADDRESS_WIDTH:0]  wc_q, wc_d;
  logic [ADDRESS_WIDTH:0]  len_q, len_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rdy_q, rdy_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
  logic [7:0]              sum_q, sum_d;
`endif

  logic                    fire;
  logic [32:0]             len_word;
  logic [32:0]             capacity;
  logic [ADDRESS_WIDTH:0]  wc_inc;

  assign fire     = rx_valid && rdy_q;
  assign len_word = {1'b0, rx_data, buf_q};
  assign capacity = 33'd1 << ADDRESS_WIDTH;
  assign wc_inc   = wc_q + (ADDRESS_WIDTH+1)'(1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bcnt_d  = bcnt_q;
    wc_d    = wc_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN;
          buf_d   = '0;
          bcnt_d  = '0;
          wc_d    = '0;
          len_d   = '0;
          err_d   = 1'b0;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (fire) begin
          buf_d  = {rx_data, buf_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (len_word == 33'd0) begin
              state_d = S_DONE;
            end else if (len_word > capacity) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              len_d   = len_word[ADDRESS_WIDTH:0];
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          buf_d  = {rx_data, buf_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            wdata_d = DATA_WIDTH'({rx_data, buf_q});
            addr_d  = 32'({wc_q, 2'b00});
            we_d    = 1'b1;
            wc_d    = wc_inc;
            if (wc_inc == len_q) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
        state_d = S_CSUM;
`else
        state_d = S_DONE;
`endif
      end
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (fire) begin
          if (8'(sum_q + rx_data) != 8'd0) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    rdy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d = (state_d == S_LEN) || (state_d == S_DATA) ||
             (state_d == S_FLUSH) || (state_d == S_CSUM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      bcnt_q  <= '0;
      wc_q    <= '0;
      len_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bcnt_q  <= bcnt_d;
      wc_q    <= wc_d;
      len_q   <= len_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef INSTRMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign rx_ready   = rdy_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instrmem_loader.sv
// Scoreboard bench for instrmem_loader (ADDRESS_WIDTH=4); follows INSTRMEM_LOADER_CHECKSUM_EN if defined.
module tb_instrmem_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   exp_q[$];
  logic [31:0]   words[16];
  logic          prev_we = 1'b0;

`ifdef INSTRMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  instrmem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we) begin
      chk("no_back_to_back_we", 64'(prev_we), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
      end else begin
        chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
    prev_we = mem_we;
  end

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctrl"}, 64'({rx_ready, mem_we, busy, done, err, word_count}), 64'd0);
    chk({name, "_bus"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  // drivers: all start and end just after a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    cnt = 0;
    while (!rx_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 within 100 cycles");
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_to_busy_ready", 64'({busy, rx_ready}), 64'd3);
  endtask

  task automatic load(input logic [31:0] len, input int nwords, input int maxgap, input bit corrupt);
    logic [7:0] sum;
    logic [7:0] b;
    do_start();
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], $urandom_range(0, maxgap));
    sum = 8'd0;
    if (maxgap > 0) start = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back({32'(i * 4), words[i]});
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        sum = sum + b;
        send_byte(b, $urandom_range(0, maxgap));
      end
    end
    start = 1'b0;
    if (CSUM && nwords > 0) send_byte(8'(8'd0 - sum) + 8'(corrupt), $urandom_range(0, maxgap));
  endtask

  task automatic check_end(input string name, input int exp_wc, input bit exp_err, input int exp_lat);
    int lat;
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    if (exp_lat >= 0) chk({name, "_done_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_word_count"}, 64'(word_count), 64'(exp_wc));
    chk({name, "_err"}, 64'(err), 64'(exp_err));
    chk({name, "_busy_ready"}, 64'({busy, rx_ready}), 64'd0);
    chk({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom_range(0, 255));
      #1;
      chk_reset_outputs("reset_hold");
    end
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", 64'({busy, done, err, rx_ready}), 64'd0);

    // two-word program, contiguous bytes
    words[0] = 32'h00A00513;
    words[1] = 32'h00B00593;
    load(32'd2, 2, 0, 1'b0);
    check_end("two_word", 2, 1'b0, CSUM ? 0 : 1);

    // same stream with rx_valid gaps and start held during data
    load(32'd2, 2, 3, 1'b0);
    check_end("two_word_gaps", 2, 1'b0, -1);

    if (CSUM) begin
      load(32'd2, 2, 2, 1'b1);
      check_end("bad_checksum", 2, 1'b1, -1);
    end

    // zero length
    load(32'd0, 0, 0, 1'b0);
    check_end("zero_len", 0, 1'b0, 0);

    // reset in the middle of the first word
    do_start();
    for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 2 : 0), 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_word_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_mid_reset_idle", 64'({busy, done, rx_ready}), 64'd0);
    load(32'd2, 2, 0, 1'b0);
    check_end("reload", 2, 1'b0, CSUM ? 0 : 1);

    // length one past capacity
    load(32'd17, 0, 0, 1'b0);
    check_end("overflow_len", 0, 1'b1, 0);

    // exactly capacity: last write at 0x3C
    for (int i = 0; i < 16; i++) words[i] = (32'h01020304 * 32'(i + 1)) ^ 32'hA5A55A5A;
    load(32'd16, 16, 0, 1'b0);
    check_end("full_capacity", 16, 1'b0, CSUM ? 0 : 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
